// File: rtl/ysyx_25060170_inst_fetch.sv
// Instruction fetch stage: one AXI4-Lite read per PC, result held for the IDU.
// Optional IFETCH_PERF_EN adds fetch / stall performance counters.
module ysyx_25060170_inst_fetch #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    input  logic        flush_i,
    output logic        pc_adv_o,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
`ifdef IFETCH_PERF_EN
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_stall_o,
`endif
    output logic        inst_fault_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_e;

    state_e      state_q, state_d;
    logic        drop_q, drop_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        fault_q, fault_d;
    logic        arvalid_q, arvalid_d;
    logic        rready_q, rready_d;
    logic        valid_q, valid_d;
    logic        start;
    logic        bus_err;

    assign start   = pc_valid_i & ~flush_i;
    assign bus_err = (rresp_i != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            drop_q    <= 1'b0;
            pc_q      <= 32'h0;
            inst_q    <= 32'h0;
            fault_q   <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            fault_q   <= fault_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        fault_d = fault_q;
        unique case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (start) begin
                    pc_d = pc_i;
                    if (pc_i[1:0] != 2'b00) begin
                        state_d = S_HOLD;
                        inst_d  = NOP_INST;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                // Address phase is never withdrawn; a flush only marks it dead.
                if (flush_i)
                    drop_d = 1'b1;
                if (arready_i)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rvalid_i) begin
                    if (drop_q | flush_i) begin
                        state_d = S_IDLE;
                        drop_d  = 1'b0;
                    end else begin
                        state_d = S_HOLD;
                        fault_d = bus_err;
                        inst_d  = bus_err ? NOP_INST : rdata_i;
                    end
                end else if (flush_i) begin
                    drop_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (flush_i | inst_ready_i)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        arvalid_d = (state_d == S_REQ);
        rready_d  = (state_d == S_WAIT);
        valid_d   = (state_d == S_HOLD);
        pc_adv_o  = valid_q & inst_ready_i & ~flush_i;
    end

    assign araddr_o     = pc_q;
    assign arvalid_o    = arvalid_q;
    assign rready_o     = rready_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = pc_q;
    assign inst_valid_o = valid_q;
    assign inst_fault_o = fault_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_q <= 32'h0;
            perf_stall_q <= 32'h0;
        end else begin
            if (pc_adv_o)
                perf_fetch_q <= perf_fetch_q + 32'd1;
            if (state_q == S_REQ || state_q == S_WAIT)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_fetch_o = perf_fetch_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_ysyx_25060170_inst_fetch.sv
// Bench for ysyx_25060170_inst_fetch: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_ysyx_25060170_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i, flush_i;
    logic        pc_adv_o;
    logic [31:0] araddr_o;
    logic        arvalid_o, arready_i;
    logic [31:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rvalid_i, rready_o;
    logic [31:0] inst_o, inst_pc_o;
    logic        inst_valid_o, inst_ready_i, inst_fault_o;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_o, perf_stall_o;
`endif

    always #5 clk = ~clk;

    ysyx_25060170_inst_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .pc_valid_i   (pc_valid_i),
        .flush_i      (flush_i),
        .pc_adv_o     (pc_adv_o),
        .araddr_o     (araddr_o),
        .arvalid_o    (arvalid_o),
        .arready_i    (arready_i),
        .rdata_i      (rdata_i),
        .rresp_i      (rresp_i),
        .rvalid_i     (rvalid_i),
        .rready_o     (rready_o),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .inst_ready_i (inst_ready_i),
`ifdef IFETCH_PERF_EN
        .perf_fetch_o (perf_fetch_o),
        .perf_stall_o (perf_stall_o),
`endif
        .inst_fault_o (inst_fault_o)
    );

    int nvec = 0;
    int nerr = 0;

    // Transaction-level model: what the fetch stage currently owes.
    bit          m_addr, m_data, m_hold, m_drop, m_fault;
    logic [31:0] m_pc, m_inst;
    int          m_nadv, m_nstall;

    // Memory responder and observation counters.
    bit          mem_pend, rv_allow, force_err, err_en;
    logic [31:0] pend_addr;
    logic [1:0]  pend_resp;
    int          n_adv, n_valid, n_ar;

    function automatic logic [31:0] memword(input logic [31:0] a);
        if (a == 32'h8000_0000)
            return 32'h0000_0297;
        return {a[15:0], ~a[31:16]} ^ 32'h1234_5678;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_addr = 0; m_data = 0; m_hold = 0; m_drop = 0; m_fault = 0;
        m_pc = 32'h0; m_inst = 32'h0;
        m_nadv = 0; m_nstall = 0;
        mem_pend = 0;
    endtask

    task automatic drv(input bit pv, input bit fl, input bit ar,
                       input bit rv, input bit ir);
        pc_valid_i = pv; flush_i = fl; arready_i = ar;
        rv_allow = rv; inst_ready_i = ir;
    endtask

    // One clock: entered and left at a falling edge.
    task automatic step();
        bit e_adv;
        rvalid_i = mem_pend & rv_allow;
        rdata_i  = rvalid_i ? memword(pend_addr) : $urandom;
        rresp_i  = rvalid_i ? pend_resp : 2'b00;
        #1;
        e_adv = m_hold & inst_ready_i & ~flush_i;
        chk("arvalid", {31'h0, arvalid_o}, {31'h0, m_addr});
        chk("rready", {31'h0, rready_o}, {31'h0, m_data});
        chk("inst_valid", {31'h0, inst_valid_o}, {31'h0, m_hold});
        chk("pc_adv", {31'h0, pc_adv_o}, {31'h0, e_adv});
        if (m_addr)
            chk("araddr", araddr_o, m_pc);
        if (m_hold) begin
            chk("inst", inst_o, m_inst);
            chk("inst_pc", inst_pc_o, m_pc);
            chk("fault", {31'h0, inst_fault_o}, {31'h0, m_fault});
        end
        if (pc_adv_o) n_adv++;
        if (inst_valid_o) n_valid++;
        if (arvalid_o) n_ar++;
        if (rvalid_i && rready_o)
            mem_pend = 0;
        if (arvalid_o && arready_i) begin
            mem_pend  = 1;
            pend_addr = araddr_o;
            if (force_err)
                pend_resp = 2'b10;
            else if (err_en && $urandom_range(0, 7) == 0)
                pend_resp = 2'($urandom_range(1, 3));
            else
                pend_resp = 2'b00;
        end
        if (e_adv) m_nadv++;
        if (m_addr || m_data) m_nstall++;
        if (m_hold) begin
            if (flush_i || inst_ready_i) m_hold = 0;
        end else if (m_addr) begin
            if (flush_i) m_drop = 1;
            if (arready_i) begin m_addr = 0; m_data = 1; end
        end else if (m_data) begin
            if (rvalid_i) begin
                m_data = 0;
                if (!(m_drop || flush_i)) begin
                    m_hold  = 1;
                    m_fault = (rresp_i != 2'b00);
                    m_inst  = m_fault ? NOP : memword(m_pc);
                end
                m_drop = 0;
            end else if (flush_i) begin
                m_drop = 1;
            end
        end else begin
            m_drop = 0;
            if (pc_valid_i && !flush_i) begin
                m_pc = pc_i;
                if (pc_i[1:0] != 2'b00) begin
                    m_hold = 1; m_fault = 1; m_inst = NOP;
                end else begin
                    m_addr = 1;
                end
            end
        end
        @(posedge clk);
        #1;
        if (e_adv) pc_i = pc_i + 32'd4;
        @(negedge clk);
    endtask

    task automatic zero_outputs(input string tag);
        chk({tag, "_arvalid"}, {31'h0, arvalid_o}, 32'h0);
        chk({tag, "_rready"}, {31'h0, rready_o}, 32'h0);
        chk({tag, "_valid"}, {31'h0, inst_valid_o}, 32'h0);
        chk({tag, "_fault"}, {31'h0, inst_fault_o}, 32'h0);
        chk({tag, "_pc_adv"}, {31'h0, pc_adv_o}, 32'h0);
        chk({tag, "_araddr"}, araddr_o, 32'h0);
        chk({tag, "_inst"}, inst_o, 32'h0);
        chk({tag, "_inst_pc"}, inst_pc_o, 32'h0);
    endtask

    task automatic clear_obs();
        n_adv = 0; n_valid = 0; n_ar = 0;
    endtask

    initial begin
        rst = 1'b1;
        pc_i = 32'h0; rdata_i = 32'h0; rresp_i = 2'b00; rvalid_i = 1'b0;
        force_err = 0; err_en = 0;
        drv(0, 0, 0, 0, 0);
        model_reset();
        clear_obs();
        repeat (2) @(negedge clk);
        zero_outputs("reset");
        rst = 1'b0;
        step();

        // Nominal fetch, minimum latency
        pc_i = 32'h8000_0000;
        drv(1, 0, 1, 1, 1);
        step();
        chk("nom_c1_arvalid", {31'h0, arvalid_o}, 32'h1);
        chk("nom_c1_araddr", araddr_o, 32'h8000_0000);
        step();
        chk("nom_c2_rready", {31'h0, rready_o}, 32'h1);
        step();
        chk("nom_c3_valid", {31'h0, inst_valid_o}, 32'h1);
        chk("nom_c3_inst", inst_o, 32'h0000_0297);
        chk("nom_c3_pc", inst_pc_o, 32'h8000_0000);
        chk("nom_c3_adv", {31'h0, pc_adv_o}, 32'h1);
        pc_valid_i = 0;
        step();
        step();

        // Misaligned PC
        pc_i = 32'h8000_0002;
        pc_valid_i = 1;
        clear_obs();
        step();
        chk("mis_valid", {31'h0, inst_valid_o}, 32'h1);
        chk("mis_fault", {31'h0, inst_fault_o}, 32'h1);
        chk("mis_inst", inst_o, NOP);
        chk("mis_pc", inst_pc_o, 32'h8000_0002);
        pc_valid_i = 0;
        step();
        chk("mis_no_ar", n_ar, 0);

        // Bus error response
        pc_i = 32'h8000_0004;
        force_err = 1;
        drv(1, 0, 1, 1, 1);
        repeat (3) step();
        chk("err_valid", {31'h0, inst_valid_o}, 32'h1);
        chk("err_fault", {31'h0, inst_fault_o}, 32'h1);
        chk("err_inst", inst_o, NOP);
        pc_valid_i = 0;
        step();
        force_err = 0;

        // Backpressure on every channel
        pc_i = 32'h8000_0008;
        drv(1, 0, 0, 0, 0);
        clear_obs();
        step();
        pc_valid_i = 0;
        repeat (3) step();
        arready_i = 1; step();
        arready_i = 0;
        repeat (2) step();
        rv_allow = 1; step();
        repeat (4) step();
        inst_ready_i = 1; step();
        step();
        chk("bp_adv_count", n_adv, 1);
        chk("bp_valid_cycles", n_valid, 5);
        chk("bp_ar_cycles", n_ar, 4);

        // Flush in REQ
        pc_i = 32'h8000_000C;
        drv(1, 0, 0, 1, 1);
        clear_obs();
        step();
        pc_valid_i = 0; flush_i = 1; step();
        flush_i = 0; arready_i = 1; step();
        repeat (3) step();
        chk("fl_req_valid", n_valid, 0);
        chk("fl_req_adv", n_adv, 0);

        // Flush in WAIT, response in the flush cycle
        drv(1, 0, 1, 0, 1);
        clear_obs();
        step();
        pc_valid_i = 0; step();
        flush_i = 1; rv_allow = 1; step();
        flush_i = 0; repeat (2) step();
        // Flush in WAIT, response later
        drv(1, 0, 1, 0, 1);
        step();
        pc_valid_i = 0; step();
        flush_i = 1; step();
        flush_i = 0; step();
        rv_allow = 1; step();
        step();
        chk("fl_wait_valid", n_valid, 0);
        chk("fl_wait_adv", n_adv, 0);

        // Flush in HOLD beats inst_ready
        drv(1, 0, 1, 1, 0);
        clear_obs();
        step();
        pc_valid_i = 0;
        repeat (2) step();
        flush_i = 1; inst_ready_i = 1; step();
        flush_i = 0; step();
        chk("fl_hold_valid", n_valid, 1);
        chk("fl_hold_adv", n_adv, 0);

        // Asynchronous reset while waiting for data
        pc_i = 32'h8000_0040;
        drv(1, 0, 1, 0, 1);
        step();
        pc_valid_i = 0; step();
        #2 rst = 1'b1;
        #1 zero_outputs("arst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        drv(1, 0, 1, 1, 1);
        repeat (3) step();
        chk("post_rst_valid", {31'h0, inst_valid_o}, 32'h1);
        chk("post_rst_pc", inst_pc_o, 32'h8000_0040);
        chk("post_rst_inst", inst_o, memword(32'h8000_0040));
        pc_valid_i = 0;
        step();

        // Randomized traffic
        err_en = 1;
        for (int i = 0; i < 4000; i++) begin
            pc_valid_i   = ($urandom_range(0, 3) != 0);
            flush_i      = ($urandom_range(0, 11) == 0);
            arready_i    = $urandom_range(0, 1);
            rv_allow     = $urandom_range(0, 1);
            inst_ready_i = ($urandom_range(0, 2) != 0);
            if (flush_i || $urandom_range(0, 39) == 0) begin
                if ($urandom_range(0, 5) == 0)
                    pc_i = $urandom;
                else
                    pc_i = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            end
            step();
        end
        drv(0, 0, 1, 1, 1);
        repeat (6) step();

`ifdef IFETCH_PERF_EN
        chk("perf_fetch", perf_fetch_o, m_nadv);
        chk("perf_stall", perf_stall_o, m_nstall);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/ysyx_25060170_inst_fetch.md
# ysyx_25060170_inst_fetch

Instruction-fetch stage sitting directly downstream of the PC register stage. Takes the current PC, issues one AXI4-Lite-style read to instruction memory, and holds the returned word for the IDU behind a valid/ready handshake. When the IDU accepts an instruction, the block emits a single-cycle `pc_adv_o` pulse that drives the PC register write enable. Only one transaction is ever outstanding.

## Interface
Parameters:
- `NOP_INST`, default 32'h0000_0013: word driven on `inst_o` for faulted fetches.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `rst`  in  1  — reset, asynchronous and active-high.
- `pc_i`  in  32  — current PC from the PC register.
- `pc_valid_i`  in  1  — `pc_i` is stable and a fetch may start.
- `flush_i`  in  1  — redirect; discard the in-flight or held instruction.
- `pc_adv_o`  out  1  — 1-cycle pulse on IDU handoff; PC register write enable.
- `araddr_o`  out  32  — read address (registered PC).
- `arvalid_o`  out  1  — read address valid.
- `arready_i`  in  1  — memory accepts the address.
- `rdata_i`  in  32  — read data.
- `rresp_i`  in  2  — read response; nonzero means error.
- `rvalid_i`  in  1  — read data valid.
- `rready_o`  out  1  — fetch accepts read data.
- `inst_o`  out  32  — instruction to IDU.
- `inst_pc_o`  out  32  — PC of `inst_o`.
- `inst_valid_o`  out  1  — instruction valid to IDU.
- `inst_ready_i`  in  1  — IDU accepts the instruction.
- `inst_fault_o`  out  1  — fetch faulted (misaligned PC or bus error); qualified by `inst_valid_o`.

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - `pc_valid_i & !flush_i & pc_i[1:0]==0` → REQ; latch `pc_i` into `pc_q`.
  - `pc_valid_i & !flush_i & pc_i[1:0]!=0` → HOLD with `inst_o`=`NOP_INST` and fault=1. No bus transaction is issued.
  - Otherwise remain in IDLE.
- REQ:
  - `arvalid_o`=1, `araddr_o`=`pc_q`; both stay stable until `arready_i` (AXI rule; never withdrawn).
  - `arvalid_o & arready_i` → WAIT.
- WAIT:
  - `rready_o`=1.
  - On `rvalid_i`: latch `rdata_i`; set fault = (`rresp_i`!=0), with `inst_o`=`NOP_INST` when faulted; → HOLD.
- HOLD:
  - `inst_valid_o`=1; `inst_o`, `inst_pc_o` and `inst_fault_o` stay stable until handshake.
  - `inst_valid_o & inst_ready_i` → IDLE.
- `pc_adv_o` = `inst_valid_o & inst_ready_i & !flush_i`, combinational, same cycle as the handshake.
- Flush handling (`drop` flag):
  - IDLE: the start is suppressed.
  - REQ: set `drop`; the address phase still completes.
  - WAIT: set `drop`. The response is consumed and discarded, then → IDLE; this includes a response arriving in the flush cycle itself.
  - HOLD: `inst_valid_o` drops next cycle, → IDLE, no `pc_adv_o`. Flush has priority over `inst_ready_i`.
  - `drop` clears on entry to IDLE.

## Timing
- Reset values:
  - state IDLE, `drop`=0.
  - `arvalid_o`, `rready_o`, `inst_valid_o`, `inst_fault_o` and `pc_adv_o` are 0.
  - `araddr_o`, `inst_o` and `inst_pc_o` are 0.
- Reset asserted mid-transaction returns the block to IDLE immediately. Memory is reset together with the fetch stage, so an orphaned response is not tracked.
- Minimum latency, with `arready_i` high and `rvalid_i` one cycle after acceptance:
  - `pc_valid_i` sampled at cycle 0.
  - `arvalid_o` at cycle 1.
  - `rready_o` at cycle 2 (data returns).
  - `inst_valid_o` at cycle 3.
- Misaligned PC: `inst_valid_o` is asserted one cycle after sampling.
- Back-to-back fetches: the handshake cycle advances the PC; the next cycle is IDLE and samples the new PC. Throughput is 1 instruction per 4 cycles at best.
- All outputs except `pc_adv_o` are registered.

## Configuration
- `IFETCH_PERF_EN` defined: adds output ports `perf_fetch_o` [31:0] and `perf_stall_o` [31:0].
  - `perf_fetch_o` counts `pc_adv_o` pulses.
  - `perf_stall_o` counts cycles spent in REQ or WAIT.
  - Both counters reset to 0 and wrap modulo 2^32.
- `IFETCH_PERF_EN` undefined: neither the ports nor the counters exist; behaviour is otherwise identical.

## Test plan
- Nominal fetch: pc=0x8000_0000, zero-wait memory returning 0x0000_0297, `inst_ready_i`=1 → `inst_valid_o` at cycle 3 with `inst_o`=0x0000_0297 and `inst_pc_o`=0x8000_0000; `pc_adv_o` high exactly that cycle.
- Backpressure: `arready_i` low 3 cycles, `rvalid_i` delayed 2 cycles, `inst_ready_i` low 4 cycles → `araddr_o`/`arvalid_o` and `inst_o`/`inst_valid_o` held stable; exactly one `pc_adv_o` pulse.
- Faults:
  - pc=0x8000_0002 → no `arvalid_o`; `inst_valid_o` with `inst_fault_o`=1 and `inst_o`=0x0000_0013.
  - `rresp_i`=2'b10 → same fault output.
- Flush: `flush_i` in REQ, in WAIT (including the `rvalid_i` cycle) and in HOLD with `inst_ready_i`=1 → response consumed, no `inst_valid_o`, no `pc_adv_o`, back to IDLE.
- Reset: `rst` asserted in WAIT → all outputs 0 asynchronously; after release, a new fetch from the current PC completes normally. With `IFETCH_PERF_EN`, 3 fetches give `perf_fetch_o`=3, and a counter preloaded near 0xFFFF_FFFF wraps to 0.
